// File: rtl/iomem_pkg.sv
// Shared types and constants for the iomem bus initiator.
package iomem_pkg;

    localparam int IOMEM_ADDR_W = 32;
    localparam int IOMEM_DATA_W = 32;

    localparam logic [3:0] IOMEM_WSTRB_READ = 4'b0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RSP
    } iomem_state_e;

endpackage

// File: rtl/iomem_timeout_ctr.sv
// Wait-cycle counter for a pending iomem request; expired flags the last permitted cycle.
module iomem_timeout_ctr #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // Holding at the last count keeps the counter from wrapping even if enable lingers.
    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (enable && !expired) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired = (count_q == LAST_COUNT);

endmodule

// File: rtl/iomem_initiator.sv
// Issues single commands as iomem transactions and returns read data or a timeout error.
module iomem_initiator
    import iomem_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [IOMEM_ADDR_W-1:0] cmd_addr,
    input  logic [IOMEM_DATA_W-1:0] cmd_wdata,
    input  logic [3:0]              cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [IOMEM_DATA_W-1:0] rsp_rdata,
    output logic                    rsp_err,
    output logic                    busy,
    output logic                    iomem_valid,
    input  logic                    iomem_ready,
    output logic [3:0]              iomem_wstrb,
    output logic [IOMEM_ADDR_W-1:0] iomem_addr,
    output logic [IOMEM_DATA_W-1:0] iomem_wdata,
    input  logic [IOMEM_DATA_W-1:0] iomem_rdata
);

    iomem_state_e            state_q, state_d;
    logic                    iomemValid_q, iomemValid_d;
    logic [IOMEM_ADDR_W-1:0] iomemAddr_q, iomemAddr_d;
    logic [IOMEM_DATA_W-1:0] iomemWdata_q, iomemWdata_d;
    logic [3:0]              iomemWstrb_q, iomemWstrb_d;
    logic                    rspValid_q, rspValid_d;
    logic [IOMEM_DATA_W-1:0] rspRdata_q, rspRdata_d;
    logic                    rspErr_q, rspErr_d;
    logic                    ctrClear;
    logic                    ctrEnable;
    logic                    ctrExpired;

    iomem_timeout_ctr #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk     (clk),
        .resetn  (resetn),
        .clear   (ctrClear),
        .enable  (ctrEnable),
        .expired (ctrExpired)
    );

    // Ready is checked before expiry so a completion on the final cycle still counts as success.
    always_comb begin
        state_d      = state_q;
        iomemValid_d = iomemValid_q;
        iomemAddr_d  = iomemAddr_q;
        iomemWdata_d = iomemWdata_q;
        iomemWstrb_d = iomemWstrb_q;
        rspValid_d   = rspValid_q;
        rspRdata_d   = rspRdata_q;
        rspErr_d     = rspErr_q;
        ctrClear     = 1'b0;
        ctrEnable    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    iomemAddr_d  = cmd_addr;
                    iomemWdata_d = cmd_wdata;
                    iomemWstrb_d = cmd_wstrb;
                    iomemValid_d = 1'b1;
                    ctrClear     = 1'b1;
                    state_d      = REQ;
                end
            end
            REQ: begin
                if (iomem_ready) begin
                    rspRdata_d   = iomem_rdata;
                    rspErr_d     = 1'b0;
                    iomemValid_d = 1'b0;
                    rspValid_d   = 1'b1;
                    state_d      = RSP;
                end else if (ctrExpired) begin
                    rspRdata_d   = '0;
                    rspErr_d     = 1'b1;
                    iomemValid_d = 1'b0;
                    rspValid_d   = 1'b1;
                    state_d      = RSP;
                end else begin
                    ctrEnable = 1'b1;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rspValid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= IDLE;
            iomemValid_q <= 1'b0;
            iomemAddr_q  <= '0;
            iomemWdata_q <= '0;
            iomemWstrb_q <= '0;
            rspValid_q   <= 1'b0;
            rspRdata_q   <= '0;
            rspErr_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            iomemValid_q <= iomemValid_d;
            iomemAddr_q  <= iomemAddr_d;
            iomemWdata_q <= iomemWdata_d;
            iomemWstrb_q <= iomemWstrb_d;
            rspValid_q   <= rspValid_d;
            rspRdata_q   <= rspRdata_d;
            rspErr_q     <= rspErr_d;
        end
    end

    assign cmd_ready   = (state_q == IDLE);
    assign busy        = (state_q != IDLE);
    assign iomem_valid = iomemValid_q;
    assign iomem_addr  = iomemAddr_q;
    assign iomem_wdata = iomemWdata_q;
    assign iomem_wstrb = iomemWstrb_q;
    assign rsp_valid   = rspValid_q;
    assign rsp_rdata   = rspRdata_q;
    assign rsp_err     = rspErr_q;

endmodule

// File: tb/tb_iomem_initiator.sv
// Directed bench for iomem_initiator: scoreboard of expected responses plus a behavioural iomem responder.
module tb_iomem_initiator;

    localparam int TIMEOUT = 8;
    localparam logic [31:0] GPIO_ADDR = 32'h0300_0000;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        busy;
    logic        iomem_valid;
    logic        iomem_ready;
    logic [3:0]  iomem_wstrb;
    logic [31:0] iomem_addr;
    logic [31:0] iomem_wdata;
    logic [31:0] iomem_rdata;

    int          checks = 0;
    int          errors = 0;
    rsp_t        sbQueue[$];
    rsp_t        monExp;
    logic [31:0] expAddr = 32'h0;
    int          curLen = 0;
    int          lastPulseLen = 0;

    int          respReadyAt = 0;
    int          vcnt = 0;
    logic        respReady = 1'b0;
    logic        strayReady = 1'b0;
    logic [31:0] respData = 32'h0;
    logic [31:0] gpioReg = 32'h0;

    iomem_initiator #(
        .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_wstrb   (cmd_wstrb),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .busy        (busy),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata)
    );

    always #5 clk = ~clk;

    // Responder raises ready during valid cycle number respReadyAt (0 = never answers).
    always @(posedge clk) begin
        vcnt      <= iomem_valid ? vcnt + 1 : 0;
        respReady <= iomem_valid && (respReadyAt >= 2) && (vcnt == respReadyAt - 2);
        if (iomem_valid && iomem_ready && iomem_addr == GPIO_ADDR) begin
            for (int b = 0; b < 4; b++) begin
                if (iomem_wstrb[b]) gpioReg[8*b +: 8] <= iomem_wdata[8*b +: 8];
            end
        end
    end

    assign iomem_ready = respReady | strayReady;
    assign iomem_rdata = (iomem_addr == GPIO_ADDR) ? gpioReg : respData;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk) begin
        if (resetn && rsp_valid && rsp_ready) begin
            if (sbQueue.size() == 0) begin
                checkOutput("unexpected response", 32'd1, 32'd0);
            end else begin
                monExp = sbQueue.pop_front();
                checkOutput("rsp_rdata", rsp_rdata, monExp.rdata);
                checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, monExp.err});
            end
        end
    end

    always @(negedge clk) begin
        if (iomem_valid) begin
            curLen++;
            checkOutput("iomem_addr stable", iomem_addr, expAddr);
        end else if (curLen != 0) begin
            lastPulseLen = curLen;
            curLen = 0;
        end
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb,
                                 input logic [31:0] expRdata, input logic expErr, input bit expectRsp);
        int waited = 0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_wstrb = wstrb;
        expAddr   = addr;
        if (expectRsp) sbQueue.push_back('{rdata: expRdata, err: expErr});
        while (!cmd_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("command accepted in time", 32'(waited < 50), 32'd1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic waitIdle();
        int waited = 0;
        while ((busy || rsp_valid) && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("returned to idle in time", 32'(waited < 100), 32'd1);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got hang, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        resetn    = 1'b0;
        cmd_valid = 1'b0;
        cmd_addr  = '0;
        cmd_wdata = '0;
        cmd_wstrb = '0;
        rsp_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset cmd_ready", {31'b0, cmd_ready}, 32'd1);
        checkOutput("reset iomem_valid", {31'b0, iomem_valid}, 32'd0);
        checkOutput("reset rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("reset busy", {31'b0, busy}, 32'd0);
        checkOutput("reset rsp_rdata", rsp_rdata, 32'd0);
        @(negedge clk) resetn = 1'b1;

        // Write with a one-cycle registered responder: valid lasts two cycles, response after E2.
        respReadyAt = 2;
        respData    = 32'h0;
        applyStimulus(GPIO_ADDR, 32'h0000_00A5, 4'hF, 32'h0, 1'b0, 1'b1);
        checkOutput("write valid after E0", {31'b0, iomem_valid}, 32'd1);
        checkOutput("write wstrb driven", {28'b0, iomem_wstrb}, 32'hF);
        @(posedge clk); #1;
        checkOutput("write rsp_valid after E1", {31'b0, rsp_valid}, 32'd0);
        @(posedge clk); #1;
        checkOutput("write rsp_valid after E2", {31'b0, rsp_valid}, 32'd1);
        checkOutput("write valid dropped at E2", {31'b0, iomem_valid}, 32'd0);
        waitIdle();
        checkOutput("write pulse length", 32'(lastPulseLen), 32'd2);
        checkOutput("gpio register written", gpioReg, 32'h0000_00A5);

        respData = 32'h0000_0003;
        applyStimulus(32'h0600_0000, 32'h0, 4'h0, 32'h0000_0003, 1'b0, 1'b1);
        waitIdle();
        checkOutput("read pulse length", 32'(lastPulseLen), 32'd2);

        // Silent responder: valid high exactly TIMEOUT cycles, error response on the last edge.
        respReadyAt = 0;
        applyStimulus(32'h0700_0000, 32'h0, 4'h0, 32'h0, 1'b1, 1'b1);
        repeat (TIMEOUT - 1) @(posedge clk);
        #1;
        checkOutput("timeout rsp_valid before expiry", {31'b0, rsp_valid}, 32'd0);
        checkOutput("timeout valid before expiry", {31'b0, iomem_valid}, 32'd1);
        @(posedge clk); #1;
        checkOutput("timeout rsp_valid at expiry", {31'b0, rsp_valid}, 32'd1);
        checkOutput("timeout valid dropped", {31'b0, iomem_valid}, 32'd0);
        waitIdle();
        checkOutput("timeout pulse length", 32'(lastPulseLen), 32'(TIMEOUT));

        respReadyAt = TIMEOUT;
        respData    = 32'h1234_5678;
        applyStimulus(32'h0600_0004, 32'h0, 4'h0, 32'h1234_5678, 1'b0, 1'b1);
        waitIdle();
        checkOutput("last-cycle ready pulse length", 32'(lastPulseLen), 32'(TIMEOUT));

        // Response back-pressure with the next command already waiting.
        rsp_ready   = 1'b0;
        respReadyAt = 2;
        respData    = 32'h0000_BEEF;
        applyStimulus(32'h0600_0008, 32'h0, 4'h0, 32'h0000_BEEF, 1'b0, 1'b1);
        cmd_valid = 1'b1;
        cmd_addr  = 32'h0600_0010;
        cmd_wdata = 32'h1111_1111;
        cmd_wstrb = 4'h0;
        sbQueue.push_back('{rdata: 32'h0000_5A5A, err: 1'b0});
        begin
            int waited = 0;
            while (!rsp_valid && waited < 50) begin
                @(negedge clk);
                waited++;
            end
            checkOutput("stall response arrived", 32'(waited < 50), 32'd1);
        end
        respData = 32'h0000_5A5A;
        expAddr  = 32'h0600_0010;
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall rsp_valid held", {31'b0, rsp_valid}, 32'd1);
            checkOutput("stall rsp_rdata held", rsp_rdata, 32'h0000_BEEF);
            checkOutput("stall rsp_err held", {31'b0, rsp_err}, 32'd0);
            checkOutput("stall cmd_ready low", {31'b0, cmd_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(posedge clk); #1;
        checkOutput("handshake rsp_valid cleared", {31'b0, rsp_valid}, 32'd0);
        checkOutput("handshake no same-cycle accept", {31'b0, iomem_valid}, 32'd0);
        checkOutput("handshake cmd_ready", {31'b0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        checkOutput("second command issued", {31'b0, iomem_valid}, 32'd1);
        checkOutput("second command addr", iomem_addr, 32'h0600_0010);
        cmd_valid = 1'b0;
        waitIdle();

        // Reset during the first request cycle discards the command.
        respReadyAt = 0;
        applyStimulus(32'h0700_0000, 32'h0, 4'h0, 32'h0, 1'b0, 1'b0);
        resetn = 1'b0;
        #1;
        checkOutput("reset drops iomem_valid", {31'b0, iomem_valid}, 32'd0);
        checkOutput("reset no rsp_valid", {31'b0, rsp_valid}, 32'd0);
        checkOutput("reset cmd_ready high", {31'b0, cmd_ready}, 32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn     = 1'b1;
        strayReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("stray ready no valid", {31'b0, iomem_valid}, 32'd0);
            checkOutput("stray ready no rsp", {31'b0, rsp_valid}, 32'd0);
            checkOutput("stray ready idle", {31'b0, busy}, 32'd0);
        end
        strayReady = 1'b0;

        respReadyAt = 3;
        respData    = 32'hCAFE_F00D;
        applyStimulus(32'h0600_000C, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b0, 1'b1);
        waitIdle();
        checkOutput("post-reset pulse length", 32'(lastPulseLen), 32'd3);

        repeat (2) @(negedge clk);
        checkOutput("scoreboard drained", 32'(sbQueue.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
